// File: rtl/product_accumulator_if.sv
// product_accumulator_if: valid/ready stream bundle for the product accumulator.
// Carries the product input stream and the batch-result output stream.
// The slave modport is the accumulator's view; master is the producer/consumer view.
`timescale 1ns/1ps

interface product_accumulator_if #(
  parameter int ACC_W = 16
);
  // product input stream
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_prod;
  logic             in_last;
  // batch result stream
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [7:0]       out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums batches of up to TERMS unsigned 8-bit products
// into an ACC_W-bit accumulator and presents each batch sum, its term count
// and an overflow flag on a valid/ready output.
// Optional feature macro: SATURATE_EN -- when defined the accumulator clamps
// to all-ones on overflow instead of wrapping; out_ovf is reported either way.
`timescale 1ns/1ps

module product_accumulator #(
  parameter int TERMS = 4,
  parameter int ACC_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  product_accumulator_if.slave   bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0]       LAST_IDX = 8'(TERMS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [7:0]       cnt_reg;
  logic             ovf_reg;
  logic             out_valid_reg;
  logic [ACC_W-1:0] out_acc_reg;
  logic [7:0]       out_count_reg;
  logic             out_ovf_reg;

  logic             accept;
  logic             close_batch;
  logic [ACC_W-1:0] base_acc;
  logic [ACC_W:0]   sum_next;
  logic [ACC_W-1:0] acc_next;
  logic [7:0]       cnt_next;
  logic             ovf_next;

  // in_ready comes straight from the state register so it is glitch-free and
  // drops immediately when reset is asserted.
  assign bus.in_ready  = !rst && (state_reg == ACCUM);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_reg;
  assign bus.out_acc   = out_acc_reg;
  assign bus.out_count = out_count_reg;
  assign bus.out_ovf   = out_ovf_reg;

  // Post-add values for the product offered this cycle; a new batch (cnt == 0)
  // starts from zero so stale acc/ovf never leak across batches.
  always_comb begin
    base_acc    = '0;
    sum_next    = '0;
    acc_next    = '0;
    ovf_next    = 1'b0;
    cnt_next    = cnt_reg + 8'd1;
    close_batch = (cnt_reg == LAST_IDX) || bus.in_last;

    if (cnt_reg != 8'd0) begin
      base_acc = acc_reg;
    end
    sum_next = {1'b0, base_acc} + {{(ACC_W-7){1'b0}}, bus.in_prod};
    ovf_next = sum_next[ACC_W] || ((cnt_reg != 8'd0) && ovf_reg);
`ifdef SATURATE_EN
    // Once the batch has overflowed the sum stays pinned at all-ones.
    acc_next = ovf_next ? ACC_MAX : sum_next[ACC_W-1:0];
`else
    acc_next = sum_next[ACC_W-1:0];
`endif
  end

  // Batch FSM: accumulate in ACCUM, present the result in HOLD until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_acc_reg   <= '0;
      out_count_reg <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
            if (close_batch) begin
              state_reg     <= HOLD;
              out_valid_reg <= 1'b1;
              out_acc_reg   <= acc_next;
              out_count_reg <= cnt_next;
              out_ovf_reg   <= ovf_next;
            end
          end
        end
        HOLD: begin
          // Result registers are left untouched so they never move while valid.
          if (bus.out_ready) begin
            state_reg     <= ACCUM;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: drives three accumulator configurations
// (TERMS/ACC_W = 4/16, 4/9, 1/16) with a shared stimulus stream and checks each
// against a batch-level reference model through a result scoreboard.
// Honours the SATURATE_EN macro the same way the design does.
`timescale 1ns/1ps

module tb_product_accumulator;

  typedef struct {
    longint acc;
    int     cnt;
    bit     ovf;
  } res_t;

`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_prod = 8'd0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int inst, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[cfg%0d] at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
      localparam int     T    = (gi == 2) ? 1 : 4;
      localparam int     W    = (gi == 1) ? 9 : 16;
      localparam longint MAXV = (longint'(1) << W) - 1;

      product_accumulator_if #(.ACC_W(W)) bus ();

      assign bus.in_valid  = in_valid;
      assign bus.in_prod   = in_prod;
      assign bus.in_last   = in_last;
      assign bus.out_ready = out_ready;

      product_accumulator #(.TERMS(T), .ACC_W(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
      );

      res_t sb[$];
      int   batch[$];
      bit   holding    = 1'b0;
      bit   just_reset = 1'b0;
      int   n_results  = 0;

      // Reference model: collects accepted products and, when a batch closes,
      // computes the true sum with plain arithmetic and queues the result.
      initial forever begin
        @(posedge clk);
        if (rst) begin
          batch.delete();
          sb.delete();
          holding    = 1'b0;
          just_reset = 1'b1;
        end else if (holding) begin
          if (out_ready) holding = 1'b0;
        end else if (in_valid) begin
          batch.push_back(int'(in_prod));
          if (batch.size() == T || in_last) begin
            longint s;
            res_t   r;
            s = 0;
            foreach (batch[k]) s += batch[k];
            r.ovf = (s > MAXV);
            r.acc = SAT ? ((s > MAXV) ? MAXV : s) : (s & MAXV);
            r.cnt = batch.size();
            sb.push_back(r);
            batch.delete();
            holding = 1'b1;
          end
        end
      end

      // Monitor: checks handshake levels every cycle and compares any presented
      // result with the scoreboard head, popping it on the handshake.
      initial forever begin
        @(negedge clk);
        if (just_reset) begin
          check("rst_out_valid", gi, longint'(bus.out_valid), 0);
          check("rst_out_acc",   gi, longint'(bus.out_acc),   0);
          check("rst_out_count", gi, longint'(bus.out_count), 0);
          check("rst_out_ovf",   gi, longint'(bus.out_ovf),   0);
          just_reset = 1'b0;
        end
        check("in_ready",  gi, longint'(bus.in_ready),  longint'(!rst && !holding));
        check("out_valid", gi, longint'(bus.out_valid), longint'(holding));
        if (bus.out_valid === 1'b1) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result[cfg%0d] at %0t: got out_acc %0d, expected no result",
                     gi, $time, bus.out_acc);
          end else begin
            check("out_acc",   gi, longint'(bus.out_acc),   sb[0].acc);
            check("out_count", gi, longint'(bus.out_count), longint'(sb[0].cnt));
            check("out_ovf",   gi, longint'(bus.out_ovf),   longint'(sb[0].ovf));
            if (out_ready && !rst) begin
              void'(sb.pop_front());
              n_results++;
            end
          end
        end
      end

      // End of run: every predicted result must have been delivered.
      initial begin
        wait (done);
        check("leftover_results", gi, longint'(sb.size()), 0);
        check("results_seen",     gi, longint'(n_results > 10), 1);
      end
    end
  endgenerate

  task automatic cyc(input bit r, input bit v, input int p, input bit l, input bit o);
    rst       = r;
    in_valid  = v;
    in_prod   = 8'(p);
    in_last   = l;
    out_ready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    repeat (3) cyc(1, 0, 0, 0, 0);

    // full batch of 225s
    repeat (4) cyc(0, 1, 225, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 1);

    // overflow batch, then a small batch that must clear the sticky flag
    repeat (4) cyc(0, 1, 255, 0, 1);
    cyc(0, 0, 0, 0, 1);
    repeat (4) cyc(0, 1, 1, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 1);

    // early close, then a full batch
    cyc(0, 1, 3, 0, 1);
    cyc(0, 1, 5, 1, 1);
    cyc(0, 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) cyc(0, 1, k, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 1);

    // backpressure with 99 offered while the result is held
    for (int k = 1; k <= 4; k++) cyc(0, 1, k, 0, 0);
    repeat (6) cyc(0, 1, 99, 0, 0);
    cyc(0, 1, 99, 0, 1);
    repeat (4) cyc(0, 1, 99, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1);

    // reset in the middle of a batch
    cyc(0, 1, 10, 0, 1);
    cyc(0, 1, 20, 0, 1);
    cyc(1, 0, 0, 0, 1);
    repeat (4) cyc(0, 1, 7, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 1);

    // in_last without in_valid, then back-to-back single products
    cyc(0, 0, 50, 1, 1);
    cyc(0, 1, 17, 0, 1);
    repeat (2) cyc(0, 1, 42, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 1);

    // randomized traffic, biased toward large products to exercise overflow
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) p = int'($urandom_range(240, 255));
      else                           p = int'($urandom_range(0, 255));
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, p,
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
    end

    repeat (10) cyc(0, 0, 0, 0, 1);
    done = 1'b1;
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
